// File: rtl/adder_share_pkg.sv
// Shared definitions for the serial nibble adder controller.
//   state_t : controller state encoding (IDLE, BUSY, DONE)
//   NIB_W   : width of the shared ripple adder slice
package adder_share_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Bus bundle between two requesters, the response consumer and the shared
// serial adder.
//   reqN_valid/ready : per-requester handshake
//   reqN_a/b/cin     : per-requester operands (W = 4*WORDS bits)
//   resp_valid/ready : result handshake
//   resp_id          : index of the requester that owns the result
//   resp_sum/cout    : W-bit sum and final carry-out
// master = requester/consumer side, slave = adder controller side.
interface adder_share_ctrl_if
    import adder_share_pkg::*;
#(
    parameter int WORDS = 4
);
    localparam int W = NIB_W * WORDS;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;

    logic         resp_valid;
    logic         resp_ready;
    logic         resp_id;
    logic [W-1:0] resp_sum;
    logic         resp_cout;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_sum, resp_cout
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_sum, resp_cout
    );

endinterface

// File: rtl/full_adder_4bit.sv
// 4-bit ripple-carry adder, the single datapath shared by both requesters.
//   a, b : nibble operands      cin  : carry in
//   sum  : nibble sum           cout : carry out
module full_adder_4bit
    import adder_share_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic c;

    always_comb begin
        sum = '0;
        c   = cin;
        for (int i = 0; i < NIB_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin shared serial adder. Two requesters compete for one 4-bit
// ripple adder; an accepted W-bit addition is computed one nibble per
// clock, LSB nibble first, and the result is held until consumed.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any operation in flight)
//   bus  : adder_share_ctrl_if.slave (request, operand and response signals)
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int WORDS = 4
)(
    input  logic                clk,
    input  logic                rst,
    adder_share_ctrl_if.slave   bus
);

    localparam int W   = NIB_W * WORDS;
    localparam int K_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t         state_q;
    state_t         state_d;

    logic           prio_q;     // requester favoured on a tie (1 = req1)
    logic           grant;
    logic           ready0;
    logic           ready1;
    logic           xfer;

    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   sum_q;
    logic           carry_q;
    logic           id_q;
    logic [K_W-1:0] k_q;

    logic [NIB_W-1:0]   nib_sum;
    logic               nib_cout;
    logic [W+NIB_W-1:0] sum_ext;

    // Operands shift right each BUSY cycle, so the adder always sees nibble k
    // in the low bits without a variable-index mux.
    full_adder_4bit u_adder (
        .a    (a_q[NIB_W-1:0]),
        .b    (b_q[NIB_W-1:0]),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // New sum nibble enters at the top; after WORDS shifts the LSB nibble
    // computed first has reached bit 0.
    assign sum_ext = {nib_sum, sum_q} >> NIB_W;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready0  = 1'b0;
        ready1  = 1'b0;
        grant   = 1'b0;

        if (bus.req0_valid && bus.req1_valid) begin
            grant = prio_q;
        end else begin
            grant = bus.req1_valid;
        end

        case (state_q)
            IDLE: begin
                // Readies are masked during reset so nothing is accepted on
                // the reset edge.
                if (!rst) begin
                    ready0 = bus.req0_valid && !grant;
                    ready1 = bus.req1_valid &&  grant;
                end
                if (ready0 || ready1) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (k_q == K_W'(WORDS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign xfer = ready0 || ready1;

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        id_q    <= grant;
                        prio_q  <= ~grant;
                        carry_q <= grant ? bus.req1_cin : bus.req0_cin;
                        k_q     <= '0;
                    end
                end
                BUSY: begin
                    sum_q   <= sum_ext[W-1:0];
                    carry_q <= nib_cout;
                    k_q     <= k_q + K_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Operand registers (no reset needed: only consumed in BUSY after capture)
    always_ff @(posedge clk) begin
        if (state_q == IDLE && xfer) begin
            a_q <= grant ? bus.req1_a : bus.req0_a;
            b_q <= grant ? bus.req1_b : bus.req0_b;
        end else if (state_q == BUSY) begin
            a_q <= a_q >> NIB_W;
            b_q <= b_q >> NIB_W;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_id    = id_q;
    assign bus.resp_sum   = sum_q;
    assign bus.resp_cout  = carry_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl: expected results are queued at the
// accepting handshake and checked when the response handshake completes.
module tb_adder_share_ctrl;
    import adder_share_pkg::*;

    localparam int WORDS = 4;
    localparam int W     = NIB_W * WORDS;

    typedef struct {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_share_ctrl_if #(.WORDS(WORDS)) bus();

    adder_share_ctrl #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t sb[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   accept_cyc = 0;
    logic prev_valid = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: latency on rising resp_valid, scoreboard on handshake
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1 && prev_valid == 1'b0)
            check_val("latency", cyc - accept_cyc, WORDS);
        prev_valid <= bus.resp_valid;
        if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("unexpected_resp", 1, 0);
            end else begin
                check_val("resp_id",   bus.resp_id,   sb[0].id);
                check_val("resp_sum",  bus.resp_sum,  sb[0].sum);
                check_val("resp_cout", bus.resp_cout, sb[0].cout);
                void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        if (n == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_valid = 1'b1;
        end
    endtask

    // Waits (bounded) for a ready, checks the grant, queues the expected
    // result and returns just after the accepting edge.
    task automatic do_accept(input int exp_who, output int waited);
        logic [W:0] full;
        exp_t       e;
        int         who;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waited++;
            if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) break;
        end
        if (!(bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1)) begin
            check_val("accept_timeout", 0, 1);
            @(posedge clk); #1;
            return;
        end
        check_val("one_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 0);
        who = (bus.req1_ready === 1'b1) ? 1 : 0;
        check_val("grant", who, exp_who);
        if (who == 0)
            full = {1'b0, bus.req0_a} + {1'b0, bus.req0_b} + {{W{1'b0}}, bus.req0_cin};
        else
            full = {1'b0, bus.req1_a} + {1'b0, bus.req1_b} + {{W{1'b0}}, bus.req1_cin};
        e.id   = who[0];
        e.sum  = full[W-1:0];
        e.cout = full[W];
        sb.push_back(e);
        accept_cyc = cyc + 1;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && bus.resp_valid === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        check_val("drain", {31'd0, done}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        logic s_valid, s_id, s_cout;
        logic [W-1:0] s_sum;
        bit   seen;

        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
        bus.resp_ready = 1'b1;

        @(negedge clk);
        check_val("rst_ready0",  {31'd0, bus.req0_ready}, 0);
        check_val("rst_valid",   {31'd0, bus.resp_valid}, 0);
        check_val("rst_sum",     bus.resp_sum,  0);
        check_val("rst_cout",    bus.resp_cout, 0);
        check_val("rst_id",      bus.resp_id,   0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req0_valid = 1'b0;

        // Directed sums
        drive(0, 16'h1234, 16'h4321, 1'b0); do_accept(0, w); bus.req0_valid = 1'b0; wait_drain();
        drive(1, 16'hFFFF, 16'h0001, 1'b0); do_accept(1, w); bus.req1_valid = 1'b0; wait_drain();
        drive(0, 16'h8000, 16'h8000, 1'b1); do_accept(0, w); bus.req0_valid = 1'b0; wait_drain();

        // Round robin from a fresh reset with both requesters always valid
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        drive(0, 16'h0001, 16'h0001, 1'b0);
        drive(1, 16'h0001, 16'h0001, 1'b0);
        do_accept(0, w);
        do_accept(1, w);
        do_accept(0, w);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_drain();

        // Back-pressure in DONE with req1 pending
        bus.resp_ready = 1'b0;
        drive(0, 16'h0F0F, 16'h00F1, 1'b0); do_accept(0, w); bus.req0_valid = 1'b0;
        drive(1, 16'h2222, 16'h3333, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid === 1'b1) begin seen = 1'b1; break; end
        end
        check_val("stall_resp_seen", {31'd0, seen}, 1);
        s_valid = bus.resp_valid; s_id = bus.resp_id; s_sum = bus.resp_sum; s_cout = bus.resp_cout;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("stall_valid", {31'd0, bus.resp_valid}, {31'd0, s_valid});
            check_val("stall_id",    {31'd0, bus.resp_id},    {31'd0, s_id});
            check_val("stall_sum",   bus.resp_sum,            s_sum);
            check_val("stall_cout",  {31'd0, bus.resp_cout},  {31'd0, s_cout});
            check_val("stall_ready0", {31'd0, bus.req0_ready}, 0);
            check_val("stall_ready1", {31'd0, bus.req1_ready}, 0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check_val("done_exit",    {31'd0, bus.resp_valid}, 0);
        check_val("idle_reentry", {31'd0, bus.req1_ready}, 1);
        do_accept(1, w);
        check_val("idle_wait", w, 1);
        bus.req1_valid = 1'b0;
        wait_drain();

        // Reset during the second BUSY cycle aborts the operation
        drive(0, 16'h00FF, 16'h0F01, 1'b0); do_accept(0, w); bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 16'h0102, 16'h0304, 1'b1);
        @(negedge clk);
        check_val("rst_busy_ready", {31'd0, bus.req0_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_back());
        check_val("abort_cleared", {31'd0, bus.resp_valid}, 0);
        check_val("abort_sum",     bus.resp_sum, 0);
        do_accept(0, w);
        check_val("accept_after_rst", w, 1);
        bus.req0_valid = 1'b0;
        wait_drain();

        // Random single-requester traffic
        for (int i = 0; i < 6; i++) begin
            int n;
            n = int'($urandom_range(0, 1));
            drive(n, W'($urandom), W'($urandom), 1'($urandom));
            do_accept(n, w);
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            wait_drain();
        end

        check_val("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_share_ctrl.md
ADDER_SHARE_CTRL -- requirements
Module: adder_share_ctrl

Interface
REQ-001 Parameter: WORDS, default 4, number of 4-bit nibbles per operand; operand width W = 4*WORDS.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req0_valid  in  1  requester 0 has an operation pending.
REQ-006 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-007 req0_a, req0_b  in  W  requester 0 operands.
REQ-008 req0_cin  in  1  requester 0 carry-in.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as REQ-005..008 for requester 1.
REQ-010 resp_valid  out  1  result available.
REQ-011 resp_ready  in  1  consumer takes result.
REQ-012 resp_id  out  1  requester index that owns the result.
REQ-013 resp_sum  out  W  sum; resp_cout  out  1  final carry-out.

Function
REQ-014 The block SHALL share one 4-bit ripple adder between two requesters, computing each W-bit addition serially, one nibble per cycle, LSB nibble first.
REQ-015 States SHALL be IDLE, BUSY, DONE.
REQ-016 IDLE: reqN_ready SHALL be high only for the granted requester, and only while its reqN_valid is high; a transfer occurs on valid&ready.
REQ-017 Arbitration SHALL be round-robin: if both are valid, grant the requester not served last; if one is valid, grant it.
REQ-018 On transfer the block SHALL capture a, b, cin, and id, then enter BUSY with nibble index 0; operands may change afterwards.
REQ-019 BUSY: each edge SHALL add nibble k of a and b plus the carry register, store the sum nibble, update the carry register, and increment k.
REQ-020 After nibble WORDS-1, the block SHALL enter DONE; resp_valid SHALL rise exactly WORDS edges after the accepting edge.
REQ-021 DONE: resp_valid, resp_id, resp_sum, and resp_cout SHALL be held stable until resp_ready is high; that edge returns the block to IDLE.
REQ-022 reqN_ready SHALL be low in BUSY and DONE, so at most one operation is in flight; throughput is one operation per WORDS+2 cycles minimum.
REQ-023 The result SHALL equal a + b + cin modulo 2^W; resp_cout SHALL be bit W of the full sum.
REQ-024 The round-robin pointer SHALL update only on a transfer.

Reset
REQ-025 rst SHALL force IDLE, all reqN_ready=0 for that cycle, resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, carry register=0, nibble index=0, and pointer favouring requester 0.
REQ-026 rst asserted in BUSY or DONE SHALL abort the operation; no response for it is ever produced.

Structure
REQ-027 Package adder_share_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and the nibble width constant (4).
REQ-028 The block SHALL instantiate exactly one full_adder_4bit as the shared datapath; all other logic stays in adder_share_ctrl.

Verification
REQ-029 Apply req0 a=0x1234, b=0x4321, cin=0 -> resp_sum=0x5555, resp_cout=0, resp_id=0, resp_valid 4 edges after accept.
REQ-030 Apply req1 a=0xFFFF, b=0x0001, cin=0 -> resp_sum=0x0000, resp_cout=1, resp_id=1; the carry propagates through all 4 nibbles.
REQ-031 Apply req0 a=0x8000, b=0x8000, cin=1 -> resp_sum=0x0001, resp_cout=1.
REQ-032 After reset, drive req0 and req1 valid together, each with 0x0001+0x0001 -> req0 served first; then req1 with resp_id=1; a third simultaneous request is granted to req0.
REQ-033 Hold resp_ready low 3 cycles in DONE -> outputs stable; both ready signals low; IDLE is re-entered on the edge after resp_ready rises.
REQ-034 Assert rst during the 2nd BUSY cycle -> resp_valid never rises for that operation; a new req0 is accepted in the first cycle after reset.
